axi_b_router: RTL and testbench
===============================

# axi_b_router

Parametrised AXI write-response (B channel) crossbar: routes responses from NUM_S slave ports back to NUM_M master ports, using the master index carried in the upper bits of the slave-side BID. Each master port has its own round-robin arbiter with a grant lock that holds until handshake, so different masters are served in parallel. Responses addressed to a non-existent master are sunk and counted. The block sits in the AXI interconnect, after the slave B ports and before the master B ports, and supersedes the fixed-priority single-master B router.

## Interface
Parameters:
- NUM_S, 3: number of slave ports, 2..8.
- NUM_M, 2: number of master ports, 1..(2**MST_W).
- ID_W, 4: master-side ID width.
- MST_W, 4: master-index field width. Slave-side ID width is IDS_W = MST_W+ID_W.

Ports (vectors are flattened, with port k at slice [k*w +: w]):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- BID_S  in  NUM_S*IDS_W  slave BID; bits [IDS_W-1 -: MST_W] give the master index, bits [ID_W-1:0] give the master ID.
- BRESP_S  in  NUM_S*2  slave response.
- BVALID_S  in  NUM_S  slave valid.
- BREADY_S  out  NUM_S  slave ready.
- BID_M  out  NUM_M*ID_W  master BID.
- BRESP_M  out  NUM_M*2  master response.
- BVALID_M  out  NUM_M  master valid.
- BREADY_M  in  NUM_M  master ready.
- DROP_CNT  out  8  saturating count of sunk unroutable responses.

## Operation
- Decode: slave s requests master m when BVALID_S[s] is high and its index field equals m. A field value of NUM_M or greater marks the response as unroutable.
- Unroutable responses: BREADY_S[s]=1 in the same cycle, regardless of arbitration. DROP_CNT increments once per accepted beat and saturates at 8'hFF.
- Per-master arbiter state: rr_ptr[m] (log2 NUM_S bits, wraps at NUM_S), lock[m], and gnt[m].
- Arbitration when lock[m]=0: grant the first requesting slave found scanning from rr_ptr[m] upward, with wrap-around. With no requester, BVALID_M[m]=0.
- Arbitration when lock[m]=1: the stored gnt[m] is used, and the request is not re-evaluated.
- Lock set: output valid and !ready. Lock clear: on handshake.
- On handshake: rr_ptr[m] <= gnt+1 mod NUM_S, and BREADY_S[gnt]=1 for that cycle only.
- One slave addresses exactly one master per beat, so no slave is granted twice. BREADY_S[s] is the OR over masters, which is effectively a one-hot pick.
- Ungranted slaves see BREADY_S=0 and must hold their response (AXI rule); the block does not buffer them.
- BID_M, BRESP_M: taken from the granted slave. When invalid they are driven to 0.

## Timing
- Reset values: BVALID_M=0, BID_M=0, BRESP_M=0, BREADY_S=0, DROP_CNT=0, rr_ptr=0, lock=0, output registers empty.
- Without AXI_B_OUTREG_EN: zero latency, a combinational path from BVALID_S to BVALID_M. Throughput is one beat per cycle per master.
- Once BVALID_M[m] rises, BVALID_M, BID_M and BRESP_M stay stable until BREADY_M[m], even if higher-ranked slaves start requesting.
- Simultaneous requests to one master: served in rotation. Two slaves held valid on the same master alternate beat by beat.
- Reset mid-transfer: everything clears asynchronously, and a held response is re-presented by its slave after reset.

## Configuration
- AXI_B_OUTREG_EN defined: one register stage per master port.
  - Arbiter handshake condition: !outreg_valid[m] | BREADY_M[m].
  - Latency: one cycle from slave accept to BVALID_M.
  - Full throughput is kept because the register reloads in the same cycle it drains.
  - Master outputs are driven directly from flops.
- Undefined: the purely combinational path described above.
- Arbitration order and DROP_CNT behaviour are identical in both builds.

## Test plan
Setup: NUM_S=3, NUM_M=2, ID_W=4, MST_W=4.
- Single response: slave1 sends BID=8'h13, BRESP=2'b10, with BREADY_M[1]=1. Master1 sees BID=4'h3, BRESP=2'b10, for 1 cycle (at cycle +1 with AXI_B_OUTREG_EN). BREADY_S[1] pulses once.
- Round robin: slaves 0, 1 and 2 all continuously target master0 with BREADY_M[0]=1. Grants come out in order 0,1,2,0,1,2 over 6 beats.
- Backpressure lock: slave0 targets master0 with BREADY_M[0]=0 for 5 cycles, then slave2 also raises valid. BID_M stays on slave0's ID for all 5 cycles. After ready, slave0 is accepted and slave2 goes next.
- Parallel masters: slave0 targets master0 while slave2 targets master1 in the same cycle, both readies high. Both complete in that cycle.
- Unroutable: slave1 sends BID=8'h53 (index 5). BREADY_S[1]=1 immediately, no BVALID_M is raised, and DROP_CNT goes 0→1. Sending 300 such beats saturates DROP_CNT at 8'hFF.
- Async reset: assert rst low mid-lock. All outputs go to 0 immediately. After release, grant restarts from slave0.

Source files
------------

// File: rtl/axi_b_router_if.sv
// axi_b_router_if: bundle of the AXI write-response signals around the B router.
//   Slave side  : BID_S, BRESP_S, BVALID_S (toward the router), BREADY_S (back).
//   Master side : BID_M, BRESP_M, BVALID_M (toward masters), BREADY_M (back).
//   DROP_CNT    : saturating count of unroutable responses that were sunk.
// Vectors are flattened: port k occupies slice [k*w +: w].
// Modports: slave  - the router's view (consumes slave B, drives master B).
//           master - the surrounding fabric's view (the mirror image).
interface axi_b_router_if #(
  parameter int NUM_S = 3,
  parameter int NUM_M = 2,
  parameter int ID_W  = 4,
  parameter int MST_W = 4
);
  localparam int IDS_W = MST_W + ID_W;

  logic [NUM_S*IDS_W-1:0] BID_S;
  logic [NUM_S*2-1:0]     BRESP_S;
  logic [NUM_S-1:0]       BVALID_S;
  logic [NUM_S-1:0]       BREADY_S;
  logic [NUM_M*ID_W-1:0]  BID_M;
  logic [NUM_M*2-1:0]     BRESP_M;
  logic [NUM_M-1:0]       BVALID_M;
  logic [NUM_M-1:0]       BREADY_M;
  logic [7:0]             DROP_CNT;

  modport slave (
    input  BID_S, BRESP_S, BVALID_S, BREADY_M,
    output BREADY_S, BID_M, BRESP_M, BVALID_M, DROP_CNT
  );

  modport master (
    output BID_S, BRESP_S, BVALID_S, BREADY_M,
    input  BREADY_S, BID_M, BRESP_M, BVALID_M, DROP_CNT
  );
endinterface

// File: rtl/axi_b_router.sv
// axi_b_router: AXI write-response crossbar, NUM_S slave ports to NUM_M master
// ports. The upper MST_W bits of each slave BID select the destination master;
// the lower ID_W bits are forwarded as the master BID. Every master port has a
// private round-robin arbiter whose grant is locked while the output is stalled,
// so distinct masters progress in parallel. Responses whose index field is
// NUM_M or more are accepted at once, discarded, and counted in DROP_CNT.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-low reset (clears state and blanks all outputs)
//   bus  - axi_b_router_if.slave (BID_S/BRESP_S/BVALID_S/BREADY_S,
//          BID_M/BRESP_M/BVALID_M/BREADY_M, DROP_CNT)
// Build option: define AXI_B_OUTREG_EN to put one register stage on each master
// port (one cycle latency, full throughput). Undefined: combinational path.
module axi_b_router #(
  parameter int NUM_S = 3,
  parameter int NUM_M = 2,
  parameter int ID_W  = 4,
  parameter int MST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  axi_b_router_if.slave   bus
);
  localparam int IDS_W = MST_W + ID_W;
  localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [MST_W-1:0] idx [NUM_S];
  logic [NUM_S-1:0] drop;
  logic [NUM_S-1:0] req [NUM_M];
  logic [3:0]       drop_n;

  logic [PTR_W-1:0] rr_ptr [NUM_M];
  logic [PTR_W-1:0] gnt    [NUM_M];
  logic [NUM_M-1:0] lock;

  logic [NUM_M-1:0] arb_vld;
  logic [PTR_W-1:0] arb_sel [NUM_M];
  logic [NUM_M-1:0] hs_ok;
  logic [NUM_M-1:0] arb_hs;
  logic [ID_W-1:0]  sel_id   [NUM_M];
  logic [1:0]       sel_resp [NUM_M];
  logic [NUM_S-1:0] bready_s;
  logic [7:0]       drop_cnt;

  // Decode: requests are blanked while reset is held so nothing is accepted.
  always_comb begin
    drop   = '0;
    drop_n = '0;
    for (int m = 0; m < NUM_M; m++) req[m] = '0;
    for (int s = 0; s < NUM_S; s++) begin
      idx[s]  = bus.BID_S[s*IDS_W+ID_W +: MST_W];
      drop[s] = rst & bus.BVALID_S[s] & (int'(idx[s]) >= NUM_M);
      drop_n  = drop_n + {3'b0, drop[s]};
      for (int m = 0; m < NUM_M; m++)
        req[m][s] = rst & bus.BVALID_S[s] & (int'(idx[s]) == m);
    end
  end

  // Arbitration: scan downward so the candidate nearest rr_ptr is the last
  // one written and therefore wins.
  always_comb begin
    int cand;
    cand = 0;
    for (int m = 0; m < NUM_M; m++) begin
      arb_vld[m] = 1'b0;
      arb_sel[m] = gnt[m];
      if (lock[m]) begin
        arb_vld[m] = rst;
      end else begin
        for (int i = NUM_S - 1; i >= 0; i--) begin
          cand = int'(rr_ptr[m]) + i;
          if (cand >= NUM_S) cand = cand - NUM_S;
          if (req[m][PTR_W'(cand)]) begin
            arb_vld[m] = 1'b1;
            arb_sel[m] = PTR_W'(cand);
          end
        end
      end
    end
  end

  always_comb begin
    bready_s = drop;
    for (int m = 0; m < NUM_M; m++) begin
      sel_id[m]   = '0;
      sel_resp[m] = '0;
      arb_hs[m]   = arb_vld[m] & hs_ok[m];
      for (int s = 0; s < NUM_S; s++) begin
        if (arb_sel[m] == PTR_W'(s)) begin
          sel_id[m]   = bus.BID_S[s*IDS_W +: ID_W];
          sel_resp[m] = bus.BRESP_S[s*2 +: 2];
          if (arb_hs[m]) bready_s[s] = 1'b1;
        end
      end
    end
  end

  assign bus.BREADY_S = bready_s;
  assign bus.DROP_CNT = drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock     <= '0;
      drop_cnt <= '0;
      for (int m = 0; m < NUM_M; m++) begin
        rr_ptr[m] <= '0;
        gnt[m]    <= '0;
      end
    end else begin
      drop_cnt <= sat_add8(drop_cnt, drop_n);
      for (int m = 0; m < NUM_M; m++) begin
        if (arb_hs[m]) begin
          lock[m]   <= 1'b0;
          rr_ptr[m] <= (arb_sel[m] == PTR_W'(NUM_S - 1)) ? '0 : arb_sel[m] + 1'b1;
        end else if (arb_vld[m]) begin
          lock[m] <= 1'b1;
          gnt[m]  <= arb_sel[m];
        end
      end
    end
  end

`ifdef AXI_B_OUTREG_EN
  logic [NUM_M-1:0] vld_p1;
  logic [ID_W-1:0]  id_p1   [NUM_M];
  logic [1:0]       resp_p1 [NUM_M];

  assign hs_ok = ~vld_p1 | bus.BREADY_M;

  // Stage p0 -> p1: the register reloads in the same cycle it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= '0;
      for (int m = 0; m < NUM_M; m++) begin
        id_p1[m]   <= '0;
        resp_p1[m] <= '0;
      end
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        if (arb_hs[m]) begin
          vld_p1[m]  <= 1'b1;
          id_p1[m]   <= sel_id[m];
          resp_p1[m] <= sel_resp[m];
        end else if (bus.BREADY_M[m]) begin
          vld_p1[m]  <= 1'b0;
          id_p1[m]   <= '0;
          resp_p1[m] <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.BVALID_M = vld_p1;
    bus.BID_M    = '0;
    bus.BRESP_M  = '0;
    for (int m = 0; m < NUM_M; m++) begin
      bus.BID_M[m*ID_W +: ID_W] = id_p1[m];
      bus.BRESP_M[m*2 +: 2]     = resp_p1[m];
    end
  end
`else
  assign hs_ok = bus.BREADY_M;

  always_comb begin
    bus.BVALID_M = arb_vld;
    bus.BID_M    = '0;
    bus.BRESP_M  = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (arb_vld[m]) begin
        bus.BID_M[m*ID_W +: ID_W] = sel_id[m];
        bus.BRESP_M[m*2 +: 2]     = sel_resp[m];
      end
    end
  end
`endif
endmodule

// File: tb/tb_axi_b_router.sv
// tb_axi_b_router: self-checking bench for axi_b_router (NUM_S=3, NUM_M=2,
// ID_W=4, MST_W=4). Slave-side beats are queued per slave and presented in
// order, each held until BREADY_S; expected master-side beats are pushed to a
// per-master scoreboard and compared on every master handshake.
module tb_axi_b_router;
  localparam int NUM_S = 3;
  localparam int NUM_M = 2;
  localparam int ID_W  = 4;
  localparam int MST_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_b_router_if #(.NUM_S(NUM_S), .NUM_M(NUM_M), .ID_W(ID_W), .MST_W(MST_W)) bif ();

  axi_b_router #(.NUM_S(NUM_S), .NUM_M(NUM_M), .ID_W(ID_W), .MST_W(MST_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks = 0;
  int failures = 0;

  logic [9:0] sbuf [NUM_S][0:511];
  int         shead [NUM_S];
  int         stail [NUM_S];
  logic [5:0] eq0 [$];
  logic [5:0] eq1 [$];
  logic [NUM_M-1:0] m_ready = '0;
  logic [NUM_S-1:0] acc;

  // Scoreboard: every master handshake must match the next expected beat.
  always @(negedge clk) begin
    logic [5:0] got;
    logic [5:0] exp_v;
    if (rst) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (bif.BVALID_M[m] && bif.BREADY_M[m]) begin
          got = {bif.BID_M[m*ID_W +: ID_W], bif.BRESP_M[m*2 +: 2]};
          checks++;
          if ((m == 0 && eq0.size() == 0) || (m == 1 && eq1.size() == 0)) begin
            failures++;
            $display("FAIL sb_unexpected m%0d got=%h exp=none t=%0t", m, got, $time);
          end else begin
            exp_v = (m == 0) ? eq0.pop_front() : eq1.pop_front();
            if (got !== exp_v) begin
              failures++;
              $display("FAIL sb_beat m%0d got={id,resp}=%h exp=%h t=%0t", m, got, exp_v, $time);
            end
          end
        end
      end
    end
  end

  task automatic push_s(input int s, input logic [7:0] id, input logic [1:0] resp);
    sbuf[s][stail[s]] = {id, resp};
    stail[s]++;
  endtask

  task automatic drive_heads();
    logic [NUM_S*8-1:0] id_v;
    logic [NUM_S*2-1:0] rs_v;
    logic [NUM_S-1:0]   vl_v;
    id_v = '0; rs_v = '0; vl_v = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (shead[s] != stail[s]) begin
        vl_v[s]          = 1'b1;
        id_v[s*8 +: 8]   = sbuf[s][shead[s]][9:2];
        rs_v[s*2 +: 2]   = sbuf[s][shead[s]][1:0];
      end
    end
    bif.BID_S    = id_v;
    bif.BRESP_S  = rs_v;
    bif.BVALID_S = vl_v;
  endtask

  // One clock: note accepted beats, advance slave queues after the edge,
  // apply master readiness, return at the following negedge.
  task automatic step();
    acc = bif.BVALID_S & bif.BREADY_S;
    @(posedge clk);
    #1;
    for (int s = 0; s < NUM_S; s++)
      if (acc[s] && shead[s] != stail[s]) shead[s]++;
    bif.BREADY_M = m_ready;
    drive_heads();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bif.BVALID_M, bif.BID_M, bif.BRESP_M, bif.BREADY_S, bif.DROP_CNT} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b id=%h resp=%h rdyS=%b drop=%h exp all 0",
               bif.BVALID_M, bif.BID_M, bif.BRESP_M, bif.BREADY_S, bif.DROP_CNT);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int rdy_cnt = 0;
    int vld_cnt = 0;
    m_ready = 2'b11;
    push_s(1, 8'h13, 2'b10);
    eq1.push_back({4'h3, 2'b10});
    step();
`ifndef AXI_B_OUTREG_EN
    checks++;
    if (bif.BVALID_M[1] !== 1'b1 || bif.BID_M[7:4] !== 4'h3 || bif.BRESP_M[3:2] !== 2'b10) begin
      failures++;
      $display("FAIL single_first got vld=%b id=%h resp=%b exp 1/3/10",
               bif.BVALID_M[1], bif.BID_M[7:4], bif.BRESP_M[3:2]);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      if (bif.BREADY_S[1]) rdy_cnt++;
      if (bif.BVALID_M[1]) vld_cnt++;
      step();
    end
    checks++;
    if (rdy_cnt != 1 || vld_cnt != 1) begin
      failures++;
      $display("FAIL single_pulses got rdyS=%0d vldM=%0d exp 1/1", rdy_cnt, vld_cnt);
    end
  endtask

  task automatic test_round_robin();
    m_ready = 2'b11;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NUM_S; s++) begin
        push_s(s, {4'h0, 4'(s + 4 * k)}, 2'(s));
        eq0.push_back({4'(s + 4 * k), 2'(s)});
      end
    for (int c = 0; c < 9; c++) step();
    checks++;
    if (eq0.size() != 0) begin
      failures++;
      $display("FAIL rr_drain got pending=%0d exp 0", eq0.size());
    end
  endtask

  task automatic test_backpressure();
    m_ready = 2'b11;
    push_s(1, 8'h0A, 2'b00);
    eq0.push_back({4'hA, 2'b00});
    for (int c = 0; c < 3; c++) step();
    m_ready = 2'b10;
    push_s(0, 8'h07, 2'b01);
    eq0.push_back({4'h7, 2'b01});
    step();
`ifndef AXI_B_OUTREG_EN
    checks++;
    if (bif.BVALID_M[0] !== 1'b1 || bif.BID_M[3:0] !== 4'h7) begin
      failures++;
      $display("FAIL bp_first got vld=%b id=%h exp 1/7", bif.BVALID_M[0], bif.BID_M[3:0]);
    end
`endif
    for (int c = 1; c < 8; c++) begin
      if (c == 4) begin
        push_s(2, 8'h0C, 2'b11);
        eq0.push_back({4'hC, 2'b11});
      end
      step();
      checks++;
      if (bif.BVALID_M[0] !== 1'b1 || bif.BID_M[3:0] !== 4'h7 || bif.BRESP_M[1:0] !== 2'b01) begin
        failures++;
        $display("FAIL bp_hold c%0d got vld=%b id=%h resp=%b exp 1/7/01",
                 c, bif.BVALID_M[0], bif.BID_M[3:0], bif.BRESP_M[1:0]);
      end
`ifndef AXI_B_OUTREG_EN
      checks++;
      if (bif.BREADY_S !== 3'b000) begin
        failures++;
        $display("FAIL bp_rdys c%0d got=%b exp=000", c, bif.BREADY_S);
      end
`endif
    end
    m_ready = 2'b11;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (eq0.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got pending=%0d exp 0", eq0.size());
    end
  endtask

  task automatic test_parallel();
    m_ready = 2'b11;
    push_s(0, 8'h02, 2'b01);
    push_s(2, 8'h19, 2'b10);
    eq0.push_back({4'h2, 2'b01});
    eq1.push_back({4'h9, 2'b10});
    step();
    checks++;
    if (bif.BREADY_S !== 3'b101) begin
      failures++;
      $display("FAIL par_rdys got=%b exp=101", bif.BREADY_S);
    end
`ifndef AXI_B_OUTREG_EN
    checks++;
    if (bif.BVALID_M !== 2'b11) begin
      failures++;
      $display("FAIL par_vld got=%b exp=11", bif.BVALID_M);
    end
`endif
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (eq0.size() != 0 || eq1.size() != 0) begin
      failures++;
      $display("FAIL par_drain got pending=%0d/%0d exp 0/0", eq0.size(), eq1.size());
    end
  endtask

  task automatic test_unroutable();
    int   model;
    logic pre;
    logic any_vld = 1'b0;
    m_ready = 2'b11;
    push_s(1, 8'h53, 2'b00);
    step();
    checks++;
    if (bif.BREADY_S[1] !== 1'b1 || bif.BVALID_M !== 2'b00 || bif.DROP_CNT !== 8'h00) begin
      failures++;
      $display("FAIL drop_first got rdyS1=%b vldM=%b cnt=%h exp 1/00/00",
               bif.BREADY_S[1], bif.BVALID_M, bif.DROP_CNT);
    end
    step();
    checks++;
    if (bif.DROP_CNT !== 8'h01) begin
      failures++;
      $display("FAIL drop_one got=%h exp=01", bif.DROP_CNT);
    end
    model = 1;
    for (int k = 0; k < 299; k++) push_s(1, 8'h53, 2'(k));
    for (int c = 0; c < 305; c++) begin
      pre = bif.BVALID_S[1] & bif.BREADY_S[1];
      if (bif.BVALID_M != 0) any_vld = 1'b1;
      step();
      if (pre && model < 255) model++;
      checks++;
      if (bif.DROP_CNT !== 8'(model)) begin
        failures++;
        $display("FAIL drop_count c%0d got=%h exp=%h", c, bif.DROP_CNT, 8'(model));
      end
    end
    checks++;
    if (bif.DROP_CNT !== 8'hFF || any_vld !== 1'b0) begin
      failures++;
      $display("FAIL drop_sat got cnt=%h anyvld=%b exp FF/0", bif.DROP_CNT, any_vld);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 2'b10;
    push_s(0, 8'h04, 2'b01);
    push_s(1, 8'h0B, 2'b10);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bif.BVALID_M, bif.BID_M, bif.BRESP_M, bif.BREADY_S, bif.DROP_CNT} !== '0) begin
      failures++;
      $display("FAIL arst_outputs got vld=%b id=%h resp=%h rdyS=%b drop=%h exp all 0",
               bif.BVALID_M, bif.BID_M, bif.BRESP_M, bif.BREADY_S, bif.DROP_CNT);
    end
    eq0.delete();
    eq0.push_back({4'h4, 2'b01});
    eq0.push_back({4'hB, 2'b10});
    m_ready = 2'b11;
    step();
    step();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
`ifndef AXI_B_OUTREG_EN
    checks++;
    if (bif.BVALID_M[0] !== 1'b1 || bif.BID_M[3:0] !== 4'h4) begin
      failures++;
      $display("FAIL arst_restart got vld=%b id=%h exp 1/4", bif.BVALID_M[0], bif.BID_M[3:0]);
    end
`endif
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (eq0.size() != 0) begin
      failures++;
      $display("FAIL arst_drain got pending=%0d exp 0", eq0.size());
    end
  endtask

  initial begin
    for (int s = 0; s < NUM_S; s++) begin
      shead[s] = 0;
      stail[s] = 0;
    end
    bif.BID_S    = '0;
    bif.BRESP_S  = '0;
    bif.BVALID_S = '0;
    bif.BREADY_M = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_unroutable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
